// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch FSM encoding, reset PC.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none; imported by the fetch unit and the control decoder.
package mips_pkg;

  // Opcodes understood by the control decoder; anything else is flagged illegal.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic is_legal_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the decoder/datapath.
// Latency: n/a (wiring only).
// Backpressure: imem_req_valid/ready for requests, instr_valid/ready for retire.
// Ports: master = fetch unit side, slave = memory + decoder side.
interface instr_fetch_unit_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  // Instruction memory request / response
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [31:0]          imem_req_addr;
  logic                 imem_rsp_valid;
  logic [31:0]          imem_rsp_data;
  // Held instruction towards decoder / datapath
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 pc_src;
  logic [5:0]           opcode;
  logic [4:0]           rs;
  logic [4:0]           rt;
  logic [4:0]           rd;
  logic [5:0]           funct;
  logic [15:0]          imm;
  logic [31:0]          pc;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] retired_cnt;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output instr_valid,
    input  instr_ready, pc_src,
    output opcode, rs, rt, rd, funct, imm, pc, illegal, retired_cnt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  instr_valid,
    output instr_ready, pc_src,
    input  opcode, rs, rt, rd, funct, imm, pc, illegal, retired_cnt
  );
endinterface

// File: rtl/branch_target_calc.sv
// Next-PC arithmetic: sequential PC and BEQ branch target.
// Latency: combinational.
// Backpressure: none.
// Ports: pc, imm in; pc_plus4, branch_target out (both modulo 2^32).
module branch_target_calc (
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  // Word offset: sign-extended immediate scaled by 4, so targets stay aligned.
  logic [31:0] offset;

  assign offset        = {{14{imm[15]}}, imm, 2'b00};
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + offset;

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch front end: owns PC, fetches one word, holds it for decode.
// Latency: instr_valid 2 cycles after entering FETCH (ready memory, 1-cycle rsp).
// Backpressure: request waits on imem_req_ready; held word waits on instr_ready.
// Ports: clk, rst (sync, active-high); bus = instr_fetch_unit_if.master.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          ir_q, ir_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          pc_plus4;
  logic [31:0]          branch_target;

  branch_target_calc u_branch_target_calc (
    .pc            (pc_q),
    .imm           (ir_q[15:0]),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        // Responses arriving here are stale by definition and are dropped.
        if (bus.imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          ir_d    = bus.imem_rsp_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // pc_src only matters on the retire cycle.
        if (bus.instr_ready) begin
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          pc_d    = bus.pc_src ? branch_target : pc_plus4;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is suppressed during the reset cycle itself.
  assign bus.imem_req_valid = (state_q == FETCH) && !rst;
  assign bus.imem_req_addr  = {pc_q[31:2], 2'b00};

  assign bus.instr_valid    = (state_q == HOLD);
  assign bus.opcode         = ir_q[31:26];
  assign bus.rs             = ir_q[25:21];
  assign bus.rt             = ir_q[20:16];
  assign bus.rd             = ir_q[15:11];
  assign bus.funct          = ir_q[5:0];
  assign bus.imm            = ir_q[15:0];
  assign bus.pc             = pc_q;
  // IR keeps the last word after retire, so qualify with instr_valid.
  assign bus.illegal        = bus.instr_valid && !is_legal_opcode(ir_q[31:26]);
  assign bus.retired_cnt    = cnt_q;

endmodule
